// File: rtl/rv32i_mc_ctrl_if.sv
// Instruction/data memory handshake bundle for the RV32I multi-cycle controller.
// The controller is the master; the memory system (or a bench) is the slave.
interface rv32i_mc_ctrl_if;
  logic        imem_req_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic        dmem_ack_in;

  modport master (
    output imem_req_out,
    input  imem_ack_in,
    input  imem_rdata_in,
    output dmem_req_out,
    output dmem_we_out,
    input  dmem_ack_in
  );

  modport slave (
    input  imem_req_out,
    output imem_ack_in,
    output imem_rdata_in,
    input  dmem_req_out,
    input  dmem_we_out,
    output dmem_ack_in
  );
endinterface

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, retire count, traps.
// Define RV32I_MC_CTRL_CSR_EN to accept SYSTEM opcodes with funct3!=000 as CSR operations.
module rv32i_mc_ctrl #(
  parameter int unsigned FETCH_TIMEOUT = 255,
  parameter logic [31:0] IR_RESET      = 32'h0000_0013
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  rv32i_mc_ctrl_if.master mem,
  input  logic            branch_taken_in,
  output logic [31:0]     ir_out,
  output logic [2:0]      imm_type_out,
  output logic            alu_src_a_out,
  output logic            alu_src_b_out,
  output logic            pc_we_out,
  output logic            pc_sel_out,
  output logic            rf_we_out,
  output logic [1:0]      wb_sel_out,
  output logic            trap_out,
  output logic [1:0]      trap_cause_out,
  output logic [31:0]     instret_out,
  output logic [2:0]      state_out
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  cause_q, cause_d;
  logic        imem_req_c;
  logic        dmem_req_c;

  // Instruction-class decode, always from the held instruction register.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st;
  logic       is_opimm, is_op, is_fence, is_system, is_env, is_csr, is_known;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_br     = (opcode == OPC_BRANCH);
  assign is_ld     = (opcode == OPC_LOAD);
  assign is_st     = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_fence  = (opcode == OPC_FENCE);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_env    = is_system && (funct3 == 3'b000);
`ifdef RV32I_MC_CTRL_CSR_EN
  assign is_csr    = is_system && (funct3 != 3'b000);
`else
  assign is_csr    = 1'b0;
`endif
  assign is_known  = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st
                   | is_opimm | is_op | is_fence | is_env | is_csr;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    imm_type_out = 3'b000;
    if (is_ld)                   imm_type_out = 3'b001;
    else if (is_st)              imm_type_out = 3'b010;
    else if (is_br)              imm_type_out = 3'b011;
    else if (is_lui || is_auipc) imm_type_out = 3'b100;
    else if (is_jal)             imm_type_out = 3'b101;
    else if (is_csr)             imm_type_out = 3'b110;
    else if (is_jalr)            imm_type_out = 3'b111;
  end

  always_comb begin
    wb_sel_out = 2'b00;
    if (is_ld)                  wb_sel_out = 2'b01;
    else if (is_jal || is_jalr) wb_sel_out = 2'b10;
    else if (is_csr)            wb_sel_out = 2'b11;
  end

  assign alu_src_a_out = is_auipc | is_jal | is_br;
  assign alu_src_b_out = !is_op;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    instret_d  = instret_q;
    cause_d    = cause_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    pc_we_out  = 1'b0;
    pc_sel_out = 1'b0;
    rf_we_out  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ack_in) begin
          ir_d    = mem.imem_rdata_in;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DECODE: begin
        if (!is_known) begin
          cause_d = 2'b01;
          state_d = S_TRAP;
        end else if (is_env) begin
          cause_d = 2'b11;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br || is_fence) begin
          pc_we_out  = 1'b1;
          pc_sel_out = is_br && branch_taken_in;
          instret_d  = instret_q + 32'd1;
          state_d    = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        if (mem.dmem_ack_in) begin
          if (is_st) begin
            pc_we_out = 1'b1;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we_out  = (ir_q[11:7] != 5'd0);
        pc_we_out  = 1'b1;
        pc_sel_out = is_jal || is_jalr;
        instret_d  = instret_q + 32'd1;
        state_d    = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is asynchronous, so a reset mid-access drops state at once.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_FETCH;
      ir_q      <= IR_RESET;
      cnt_q     <= '0;
      instret_q <= '0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  // Reset leaves the FSM in FETCH, so the fetch request is gated off while reset is held.
  assign mem.imem_req_out = imem_req_c && rst_n_in;
  assign mem.dmem_req_out = dmem_req_c;
  assign mem.dmem_we_out  = dmem_req_c && is_st;

  assign ir_out         = ir_q;
  assign trap_out       = (state_q == S_TRAP);
  assign trap_cause_out = cause_q;
  assign instret_out    = instret_q;
  assign state_out      = state_q;

endmodule
